// File: rtl/fntt_pkg.sv
// Shared FNTT definitions: default frame geometry, the index bit-reverse helper
// and the bank-select/count pointer used by the bit-reverse stream controller.
package fntt_pkg;

    localparam int unsigned N_DEFAULT  = 8;
    localparam int unsigned DW_DEFAULT = 8;

    // Widest index the shared bitrev helper and pointer counts support
    localparam int unsigned IDX_MAXW = 16;
    localparam int unsigned IDX_SELW = $clog2(IDX_MAXW);

    typedef struct packed {
        logic                bank;
        logic [IDX_MAXW-1:0] cnt;
    } bank_ptr_t;

    // Reverse the low w bits of idx; bits at and above w come back as zero
    function automatic logic [IDX_MAXW-1:0] bitrev(input logic [IDX_MAXW-1:0] idx,
                                                   input int unsigned        w);
        logic [IDX_MAXW-1:0] r;
        r = '0;
        for (int unsigned b = 0; b < IDX_MAXW; b++) begin
            if (b < w) begin
                r[IDX_SELW'(w - 1 - b)] = idx[IDX_SELW'(b)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bitrev_bank.sv
// One N x DW frame buffer bank: synchronous write port, combinational read port.
// Contents are intentionally not reset.
module bitrev_bank #(
    parameter int unsigned  N     = 8,
    parameter int unsigned  DW    = 8,
    localparam int unsigned LOG2N = $clog2(N)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [LOG2N-1:0] waddr,
    input  logic [DW-1:0]    wdata,
    input  logic [LOG2N-1:0] raddr,
    output logic [DW-1:0]    rdata
);

    logic [DW-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bitrev_stream_ctrl.sv
// Streaming bit-reverse permutation buffer: natural-order frames in, bit-reversed out.
// Define BITREV_PINGPONG_EN for two ping-pong banks; otherwise a single bank is used.
module bitrev_stream_ctrl
    import fntt_pkg::*;
#(
    parameter int unsigned  N     = N_DEFAULT,
    parameter int unsigned  DW    = DW_DEFAULT,
    localparam int unsigned LOG2N = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last
);

`ifdef BITREV_PINGPONG_EN
    localparam int unsigned NBANK = 2;
`else
    localparam int unsigned NBANK = 1;
`endif
    localparam logic [IDX_MAXW-1:0] LAST_IDX = IDX_MAXW'(N - 1);

    bank_ptr_t        wptr_q, wptr_d;
    bank_ptr_t        rptr_q, rptr_d;
    logic [NBANK-1:0] full_q, full_d;
    logic [NBANK-1:0] wsel, rsel, bank_we;
    logic [DW-1:0]    bank_rdata [NBANK];
    logic [DW-1:0]    rd_word;
    logic [LOG2N-1:0] wr_addr, rd_addr;
    logic             wbank_full, rbank_full;
    logic             wr_fire, rd_fire, wr_wrap, rd_wrap;

    assign wr_addr = LOG2N'(wptr_q.cnt);
    assign rd_addr = LOG2N'(bitrev(rptr_q.cnt, LOG2N));

    // Per-bank select, write enable, full-flag update and storage
    for (genvar g = 0; g < NBANK; g++) begin : g_bank
        assign wsel[g]    = (wptr_q.bank == 1'(g));
        assign rsel[g]    = (rptr_q.bank == 1'(g));
        assign bank_we[g] = wr_fire & wsel[g];
        assign full_d[g]  = (wr_fire & wr_wrap & wsel[g])
                          | (full_q[g] & ~(rd_fire & rd_wrap & rsel[g]));

        bitrev_bank #(
            .N  (N),
            .DW (DW)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we[g]),
            .waddr (wr_addr),
            .wdata (s_data),
            .raddr (rd_addr),
            .rdata (bank_rdata[g])
        );
    end

    assign wbank_full = |(full_q & wsel);
    assign rbank_full = |(full_q & rsel);

`ifdef BITREV_PINGPONG_EN
    assign rd_word = rptr_q.bank ? bank_rdata[1] : bank_rdata[0];
`else
    assign rd_word = bank_rdata[0];
`endif

    // Handshake outputs depend on registered pointers and flags only
    assign s_ready = ~wbank_full;
    assign m_valid = rbank_full;
    assign m_data  = m_valid ? rd_word : '0;
    assign wr_wrap = (wptr_q.cnt == LAST_IDX);
    assign rd_wrap = (rptr_q.cnt == LAST_IDX);
    assign m_last  = m_valid & rd_wrap;
    assign wr_fire = s_valid & s_ready;
    assign rd_fire = m_valid & m_ready;

    // Pointer next state; the bank bit only advances in the ping-pong build
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_fire) begin
            if (wr_wrap) begin
                wptr_d.cnt = '0;
`ifdef BITREV_PINGPONG_EN
                wptr_d.bank = ~wptr_q.bank;
`endif
            end else begin
                wptr_d.cnt = wptr_q.cnt + IDX_MAXW'(1);
            end
        end
        if (rd_fire) begin
            if (rd_wrap) begin
                rptr_d.cnt = '0;
`ifdef BITREV_PINGPONG_EN
                rptr_d.bank = ~rptr_q.bank;
`endif
            end else begin
                rptr_d.cnt = rptr_q.cnt + IDX_MAXW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            full_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            full_q <= full_d;
        end
    end

endmodule
